// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box tables, key-schedule steps and the inverse permutation.
// Both the encryption and the decryption datapaths build on these pure functions.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam int KEY_W  = 80;
  localparam int BLK_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    WHITEN = 2'd2,
    DEC    = 2'd3
  } fsm_t;

  function automatic logic [3:0] s_box(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_s_box(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] fwd_update(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = s_box(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  // First inverse step split out so the key nibble can go through a shared inverse S-box instance.
  function automatic logic [KEY_W-1:0] inv_key_mix(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = k;
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] rotr61(input logic [KEY_W-1:0] k);
    return {k[60:0], k[79:61]};
  endfunction

  function automatic logic [KEY_W-1:0] inv_update(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = inv_key_mix(k, rc);
    r[79:76] = inv_s_box(r[79:76]);
    return rotr61(r);
  endfunction

  function automatic logic [BLK_W-1:0] inv_p(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = 64'd0;
    for (int j = 0; j < 63; j++) begin
      r[(4 * j) % 63] = s[j];
    end
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// 4-bit PRESENT inverse S-box; one instance per state nibble plus one for the key schedule.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [3:0] datain,
  output logic [3:0] dataout
);

  assign dataout = inv_s_box(datain);

endmodule

// File: rtl/present80_decrypt.sv
// Iterative PRESENT-80 decryptor: expands the key forward to K32, whitens,
// then runs 31 inverse rounds while unrolling the key schedule backwards.
module present80_decrypt
  import present_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  input  logic [BLK_W-1:0]  datain,
  output logic              ready,
  output logic [BLK_W-1:0]  dataout,
  output logic              done
);

  fsm_t             fsm_r;
  logic [KEY_W-1:0] key_r;
  logic [BLK_W-1:0] state_r;
  logic [4:0]       cnt_r;

  logic [KEY_W-1:0] key_mix_s;
  logic [3:0]       key_nib_s;
  logic [KEY_W-1:0] round_key_s;
  logic [BLK_W-1:0] perm_s;
  logic [BLK_W-1:0] sub_s;
  logic [BLK_W-1:0] round_out_s;

  assign key_mix_s = inv_key_mix(key_r, cnt_r);

  present_inv_sbox u_key_sbox (
    .datain  (key_mix_s[79:76]),
    .dataout (key_nib_s)
  );

  assign round_key_s = rotr61({key_nib_s, key_mix_s[75:0]});
  assign perm_s      = inv_p(state_r);

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    present_inv_sbox u_sbox (
      .datain  (perm_s[4*i +: 4]),
      .dataout (sub_s[4*i +: 4])
    );
  end

  assign round_out_s = sub_s ^ round_key_s[79:16];
  assign ready       = (fsm_r == IDLE) && !rst;

  // Control FSM plus key/state/counter datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= IDLE;
      key_r   <= 80'd0;
      state_r <= 64'd0;
      cnt_r   <= 5'd0;
      dataout <= 64'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (start) begin
            key_r   <= key;
            state_r <= datain;
            cnt_r   <= 5'd1;
            fsm_r   <= EXPAND;
          end
        end
        EXPAND: begin
          key_r <= fwd_update(key_r, cnt_r);
          // Hold at the top of the range instead of wrapping; WHITEN reloads it anyway.
          if (cnt_r == 5'(ROUNDS)) begin
            fsm_r <= WHITEN;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        WHITEN: begin
          state_r <= state_r ^ key_r[79:16];
          cnt_r   <= 5'(ROUNDS);
          fsm_r   <= DEC;
        end
        DEC: begin
          key_r   <= round_key_s;
          state_r <= round_out_s;
          cnt_r   <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            dataout <= round_out_s;
            done    <= 1'b1;
            fsm_r   <= IDLE;
          end
        end
        default: fsm_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present80_decrypt.sv
// Directed bench for present80_decrypt: published PRESENT-80 vectors run in reverse,
// plus back-to-back, ignored-start and mid-operation reset sequences.
module tb_present80_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [63:0] datain;
  logic        ready;
  logic [63:0] dataout;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  present80_decrypt dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .datain  (datain),
    .ready   (ready),
    .dataout (dataout),
    .done    (done)
  );

  typedef struct {
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    key    = {16'($urandom), $urandom, $urandom};
    datain = {$urandom, $urandom};
  endtask

  // Present one start cycle, then garble the inputs so late changes would show up.
  task automatic launch(input logic [79:0] k, input logic [63:0] d);
    start  = 1'b1;
    key    = k;
    datain = d;
    tick();
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int lat);
    int c;
    c   = 0;
    lat = 0;
    while (lat == 0 && c < 100) begin
      tick();
      c++;
      if (done) lat = c;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    int first_lat;

    vecs[0] = '{key: 80'h0,                    ct: 64'h5579C1387B228445, pt: 64'h0000000000000000};
    vecs[1] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'hE72C46C0F5945049, pt: 64'h0000000000000000};
    vecs[2] = '{key: 80'h0,                    ct: 64'hA112FFC72F68417B, pt: 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'h3333DCD3213210D2, pt: 64'hFFFFFFFFFFFFFFFF};

    rst    = 1'b1;
    start  = 1'b0;
    key    = 80'd0;
    datain = 64'd0;
    tick();
    tick();
    tick();
    check("rst_ready", 80'(ready), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_dataout", 80'(dataout), 80'd0);
    rst = 1'b0;
    #1;
    check("release_ready", 80'(ready), 80'd1);
    tick();
    check("idle_ready", 80'(ready), 80'd1);
    check("idle_done", 80'(done), 80'd0);

    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].key, vecs[i].ct);
      check("busy_ready", 80'(ready), 80'd0);
      wait_done(lat);
      check("vec_latency", 80'(lat), 80'd63);
      check("vec_dataout", 80'(dataout), 80'(vecs[i].pt));
      check("done_ready", 80'(ready), 80'd1);
      tick();
      check("done_width", 80'(done), 80'd0);
      check("dataout_hold", 80'(dataout), 80'(vecs[i].pt));
    end

    // Back-to-back: second start issued in the done cycle.
    launch(vecs[2].key, vecs[2].ct);
    wait_done(lat);
    check("b2b_first_out", 80'(dataout), 80'(vecs[2].pt));
    start  = 1'b1;
    key    = vecs[3].key;
    datain = vecs[3].ct;
    tick();
    start = 1'b0;
    scramble();
    check("b2b_done_clear", 80'(done), 80'd0);
    check("b2b_busy", 80'(ready), 80'd0);
    wait_done(lat);
    check("b2b_latency", 80'(lat), 80'd63);
    check("b2b_second_out", 80'(dataout), 80'(vecs[3].pt));

    // Start pulses and input noise while busy must be ignored.
    launch(vecs[0].key, vecs[0].ct);
    done_cnt  = 0;
    first_lat = 0;
    for (int c = 1; c <= 140; c++) begin
      if (c <= 62) begin
        start = 1'($urandom_range(0, 1));
        scramble();
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        if (first_lat == 0) first_lat = c;
      end
    end
    check("noise_done_count", 80'(done_cnt), 80'd1);
    check("noise_latency", 80'(first_lat), 80'd63);
    check("noise_dataout", 80'(dataout), 80'(vecs[0].pt));

    // Reset partway through an operation aborts it silently.
    launch(vecs[1].key, vecs[1].ct);
    for (int c = 1; c < 40; c++) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready_low", 80'(ready), 80'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", 80'(ready), 80'd1);
    check("midrst_done", 80'(done), 80'd0);
    check("midrst_dataout", 80'(dataout), 80'd0);
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrst_no_late_done", 80'(done_cnt), 80'd0);
    launch(vecs[1].key, vecs[1].ct);
    wait_done(lat);
    check("postrst_latency", 80'(lat), 80'd63);
    check("postrst_dataout", 80'(dataout), 80'(vecs[1].pt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
